// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver into a first-word-fall-through FIFO (din serial in; data/valid/ready byte stream out; frame_err/overflow one-cycle pulses; count = occupancy)
module uart_rx_fifo #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic [7:0] data,
  output logic valid,
  input  logic ready,
  output logic frame_err,
  output logic overflow,
  output logic [$clog2(FIFO_DEPTH):0] count
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CPB);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t state, state_n;
  logic s1, din_s, push, ferr_n, pop, full, wr;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  assign valid = count != '0;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign pop = valid && ready;
  assign wr = push && (!full || pop);
  assign data = valid ? mem[rp] : 8'h00;
  always_comb begin
    state_n = state;
    cnt_n = cnt + CW'(1);
    idx_n = idx;
    sh_n = sh;
    push = 1'b0;
    ferr_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        state_n = din_s ? IDLE : START;
      end
      START: if (cnt == HALF) begin
        cnt_n = '0;
        idx_n = '0;
        state_n = din_s ? IDLE : DATA;
      end
      DATA: if (cnt == LAST) begin
        cnt_n = '0;
        sh_n = {din_s, sh[7:1]};
        idx_n = idx + 3'd1;
        state_n = idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (cnt == LAST) begin
        cnt_n = '0;
        push = din_s;
        ferr_n = !din_s;
        state_n = din_s ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        cnt_n = '0;
        state_n = din_s ? IDLE : WAIT_HIGH;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      din_s <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      frame_err <= 1'b0;
      overflow <= 1'b0;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      s1 <= din;
      din_s <= s1;
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      frame_err <= ferr_n;
      overflow <= push && full && !pop;
      wp <= wr ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      count <= count + (AW+1)'(wr) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk)
    if (!rst && wr) mem[wp] <= sh;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scoreboard bench for uart_rx_fifo at 10 clocks per bit, depth 4
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b1;
  logic ready = 1'b0;
  logic [7:0] data;
  logic valid, frame_err, overflow;
  logic [2:0] count;
  int total = 0;
  int bad = 0;
  int ferrs = 0;
  int ovfs = 0;
  int vcyc = 0;
  logic [7:0] exp_q [$];
  always #5 clk = ~clk;
  uart_rx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .din(din), .data(data), .valid(valid), .ready(ready),
    .frame_err(frame_err), .overflow(overflow), .count(count)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask
  task automatic send(input logic [7:0] b, input logic stop = 1'b1, input int rk = -1, input int n = 100);
    for (int k = 0; k < n; k++) begin
      din = k < 10 ? 1'b0 : k < 90 ? b[(k - 10) / 10] : stop;
      if (rk >= 0) ready = k == rk;
      tick();
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err === 1'b1) ferrs++;
      if (overflow === 1'b1) ovfs++;
      if (valid === 1'b1) vcyc++;
      if (valid === 1'b1 && ready === 1'b1) begin
        total++;
        assert (exp_q.size() != 0 && data === exp_q[0]) else begin
          bad++;
          $error("FAIL pop: got %0h want %0h (queued %0d)", data, exp_q.size() != 0 ? exp_q[0] : 8'hxx, exp_q.size());
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  end
  initial begin
    int v0, o0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 8'h00);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovf", overflow, 0);
    repeat (5) tick();
    ready = 1'b1;
    v0 = vcyc;
    exp_q.push_back(8'hA5);
    send(8'hA5);
    repeat (5) tick();
    chk("a5_valid_cycles", vcyc - v0, 1);
    chk("a5_drained", exp_q.size(), 0);
    chk("a5_count", count, 0);
    chk("a5_ferr", ferrs, 0);
    chk("a5_ovf", ovfs, 0);
    ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i < 5) exp_q.push_back(8'(i));
      send(8'(i));
    end
    repeat (3) tick();
    chk("full_count", count, 4);
    chk("full_ovf", ovfs, 1);
    chk("full_valid", valid, 1);
    chk("full_head", data, 8'h01);
    ready = 1'b1;
    repeat (6) tick();
    chk("full_drained", exp_q.size(), 0);
    chk("full_count_after", count, 0);
    send(8'h3C, 1'b0);
    din = 1'b0;
    repeat (30) tick();
    din = 1'b1;
    repeat (5) tick();
    chk("brk_ferr", ferrs, 1);
    chk("brk_count", count, 0);
    exp_q.push_back(8'h5A);
    send(8'h5A);
    repeat (5) tick();
    chk("brk_5a_drained", exp_q.size(), 0);
    chk("brk_ferr_after", ferrs, 1);
    din = 1'b0;
    repeat (3) tick();
    din = 1'b1;
    repeat (20) tick();
    chk("glitch_count", count, 0);
    chk("glitch_ferr", ferrs, 1);
    exp_q.push_back(8'hFF);
    send(8'hFF);
    repeat (5) tick();
    chk("glitch_ff_drained", exp_q.size(), 0);
    send(8'h81, 1'b1, -1, 55);
    rst = 1'b1;
    din = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_count", count, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_data", data, 8'h00);
    chk("midrst_ferr", frame_err, 0);
    repeat (20) tick();
    chk("midrst_idle_count", count, 0);
    exp_q.push_back(8'h7E);
    send(8'h7E);
    repeat (5) tick();
    chk("midrst_7e_drained", exp_q.size(), 0);
    chk("midrst_ferr_total", ferrs, 1);
    chk("midrst_ovf_total", ovfs, 1);
    ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i * 8'h11));
      send(8'(i * 8'h11));
    end
    chk("pp_full_count", count, 4);
    exp_q.push_back(8'h55);
    o0 = ovfs;
    send(8'h55, 1'b1, 97);
    chk("pp_count", count, 4);
    chk("pp_no_ovf", ovfs - o0, 0);
    chk("pp_head", data, 8'h22);
    ready = 1'b1;
    repeat (6) tick();
    chk("pp_drained", exp_q.size(), 0);
    chk("pp_count_after", count, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division), which SHALL be at least 4.
REQ-003 Parameter FIFO_DEPTH, default 4, receive buffer entries; SHALL be a power of two, 2..16.
REQ-004 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 din  input  1  asynchronous serial line; 8N1 format, LSB first, idle high; driven by the uart_send output dout/tx.
REQ-007 data  output  8  byte at the FIFO head.
REQ-008 valid  output  1  high when the FIFO is non-empty.
REQ-009 ready  input  1  consumer accepts the head byte when valid && ready.
REQ-010 frame_err  output  1  one-cycle pulse when a stop bit samples low.
REQ-011 overflow  output  1  one-cycle pulse when a received byte is dropped because the FIFO is full.
REQ-012 count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-013 din SHALL pass through a 2-flop synchronizer before any use; all timing below refers to the synchronized signal din_s.
REQ-014 The receiver FSM SHALL have exactly five states: IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-015 IDLE: on din_s == 0, go to START and clear the baud counter.
REQ-016 START: at count CLKS_PER_BIT/2-1, sample din_s. If 0, go to DATA and clear the counter and bit index. If 1, treat it as a glitch and return to IDLE with no outputs.
REQ-017 DATA: every CLKS_PER_BIT cycles, sample din_s into the shift register at bit index 0..7 (LSB first). After bit 7, go to STOP.
REQ-018 STOP: after CLKS_PER_BIT cycles, sample din_s. If 1, push the byte and go to IDLE. If 0, pulse frame_err, discard the byte and go to WAIT_HIGH.
REQ-019 WAIT_HIGH: stay until din_s == 1, then go to IDLE; a held-low (break) line SHALL NOT produce further bytes or errors.
REQ-020 The FIFO SHALL be first-word-fall-through: data equals the head entry whenever valid = 1; data is don't-care when valid = 0.
REQ-021 Pop occurs on a cycle with valid && ready. Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 Push on a non-full FIFO: valid and count update on the next cycle. There is no same-cycle bypass from push to valid.
REQ-023 Push while full with no pop: drop the new byte, pulse overflow, leave contents unchanged.
REQ-024 Push while full with a simultaneous pop: accept both, count stays FIFO_DEPTH, no overflow.
REQ-025 Simultaneous push and pop when count == 1: the head advances to the new byte, count stays 1.
REQ-026 ready while valid = 0 SHALL have no effect.
REQ-027 The FSM and FIFO SHALL operate independently; backpressure on ready never stalls reception.
REQ-028 Latency: valid rises 1 cycle after the stop-bit sample cycle.

Reset
REQ-029 On rst = 1 at a clock edge, the following SHALL hold on the next cycle:
- FSM in IDLE; baud counter, bit index and shift register at 0.
- FIFO pointers at 0; count = 0, valid = 0, data = 8'h00.
- frame_err = 0, overflow = 0.
- Synchronizer flops at 1.
REQ-030 Reset mid-frame SHALL abort the frame without a push or error pulse. Reception resumes on the next falling edge seen after reset deasserts.

Verification (CLK_FREQ=1_000_000, BAUD_RATE=100_000, i.e. CLKS_PER_BIT=10; FIFO_DEPTH=4)
REQ-031 Send 8'hA5 with ready = 1 -> valid pulses one cycle with data = 8'hA5; count returns to 0; no error pulses.
REQ-032 Hold ready = 0 and send 8'h01, 8'h02, 8'h03, 8'h04, 8'h05 -> count = 4, exactly one overflow pulse; then raising ready yields 01, 02, 03, 04 in order.
REQ-033 Send 8'h3C with the stop bit driven low, then hold din low for 30 cycles, then release high and send 8'h5A -> exactly one frame_err, 8'h3C is never output, then 8'h5A is received.
REQ-034 Drive a 3-cycle low glitch on an idle line -> no push and no error; a following 8'hFF is received correctly.
REQ-035 Assert rst for 1 cycle during bit 4 of 8'h81, then send 8'h7E -> only 8'h7E appears; reset values hold after rst.
REQ-036 With count = 4, complete a push in the same cycle as valid && ready -> no overflow, count stays 4, the new byte is last in order.
